// File: rtl/edge_detect_mc.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect_mc
// Brief    : Multi-channel synchronised edge detector with sticky flags and
//            saturating per-channel edge counters.
// Revision : 1.0 - initial release
// ============================================================================
module edge_detect_mc #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter bit INIT_LVL    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         sig_in,
    input  logic [1:0]            mode,
    input  logic [CH-1:0]         flag_clr,
    input  logic                  cnt_clr,
    output logic [CH-1:0]         edge_pulse,
    output logic [CH-1:0]         edge_flag,
    output logic [CH*CNT_W-1:0]   edge_cnt,
    output logic                  any_edge
);

    localparam logic [CH-1:0]    c_INIT_VEC  = {CH{INIT_LVL}};
    localparam logic [1:0]       c_MODE_RISE = 2'b00;
    localparam logic [1:0]       c_MODE_FALL = 2'b01;
    localparam logic [1:0]       c_MODE_BOTH = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    logic [CH-1:0] w_s;
    logic [CH-1:0] r_hist;
    logic [CH-1:0] w_rise;
    logic [CH-1:0] w_fall;
    logic [CH-1:0] w_det;
    logic [CH-1:0] r_pulse;
    logic [CH-1:0] r_flag;
    logic          r_any;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign w_s = sig_in;
        end else begin : g_sync
            logic [CH-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < SYNC_STAGES; j++) begin
                        r_sync[j] <= c_INIT_VEC;
                    end
                end else begin
                    r_sync[0] <= sig_in;
                    for (int j = 1; j < SYNC_STAGES; j++) begin
                        r_sync[j] <= r_sync[j-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Mode is applied to the raw detect combinationally, so a mode change
    // only influences edges judged from that cycle onward.
    always_comb begin
        w_rise = w_s & ~r_hist;
        w_fall = ~w_s & r_hist;
        w_det  = '0;
        case (mode)
            c_MODE_RISE: w_det = w_rise;
            c_MODE_FALL: w_det = w_fall;
            c_MODE_BOTH: w_det = w_rise | w_fall;
            default:     w_det = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist  <= c_INIT_VEC;
            r_pulse <= '0;
            r_any   <= 1'b0;
        end else begin
            r_hist  <= w_s;
            r_pulse <= w_det;
            r_any   <= |w_det;
        end
    end

    // A new edge outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= '0;
        end else begin
            r_flag <= (r_flag & ~flag_clr) | w_det;
        end
    end

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (cnt_clr) begin
                    r_cnt <= {{(CNT_W-1){1'b0}}, w_det[i]};
                end else if (w_det[i] && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign edge_cnt[i*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

    assign edge_pulse = r_pulse;
    assign edge_flag  = r_flag;
    assign any_edge   = r_any;

endmodule
`default_nettype wire

// File: tb/tb_edge_detect_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_detect_mc
// Brief    : Scoreboard bench: stimulus queues expected pulses, monitors pop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_detect_mc;

    typedef struct {
        int         cyc;
        logic [7:0] pulse;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        q0[$];
    exp_t        q2[$];

    // u0: defaults (CH=8, SYNC_STAGES=2, CNT_W=8)
    logic [7:0]  sig0, flag_clr0, pulse0, flag0;
    logic [1:0]  mode0;
    logic        cnt_clr0, any0;
    logic [63:0] cnt0;
    // u1: CH=4, CNT_W=2
    logic [3:0]  sig1, pulse1, flag1;
    logic        cnt_clr1, any1;
    logic [7:0]  cnt1;
    // u2: CH=4, SYNC_STAGES=0
    logic [3:0]  sig2, pulse2, flag2;
    logic        any2;
    logic [31:0] cnt2;
    logic [1:0]  mode_rise = 2'b00;
    logic [3:0]  no_clr4   = 4'h0;
    logic        no_cclr   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    edge_detect_mc u0 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig0), .mode(mode0),
        .flag_clr(flag_clr0), .cnt_clr(cnt_clr0), .edge_pulse(pulse0),
        .edge_flag(flag0), .edge_cnt(cnt0), .any_edge(any0)
    );

    edge_detect_mc #(.CH(4), .SYNC_STAGES(2), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig1), .mode(mode_rise),
        .flag_clr(no_clr4), .cnt_clr(cnt_clr1), .edge_pulse(pulse1),
        .edge_flag(flag1), .edge_cnt(cnt1), .any_edge(any1)
    );

    edge_detect_mc #(.CH(4), .SYNC_STAGES(0), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig2), .mode(mode_rise),
        .flag_clr(no_clr4), .cnt_clr(no_cclr), .edge_pulse(pulse2),
        .edge_flag(flag2), .edge_cnt(cnt2), .any_edge(any2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int c, input logic [7:0] p);
        exp_t e;
        e.cyc   = c;
        e.pulse = p;
        q0.push_back(e);
    endtask

    task automatic push2(input int c, input logic [7:0] p);
        exp_t e;
        e.cyc   = c;
        e.pulse = p;
        q2.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (pulse0 !== 8'h00 || any0 !== 1'b0)) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_pulse", 64'(pulse0), 64'h0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("u0_pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("u0_pulse", 64'(pulse0), 64'(e.pulse));
                check("u0_any_edge", 64'(any0), 64'h1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (pulse2 !== 4'h0 || any2 !== 1'b0)) begin
            if (q2.size() == 0) begin
                check("u2_unexpected_pulse", 64'(pulse2), 64'h0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("u2_pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("u2_pulse", 64'(pulse2), 64'(e.pulse[3:0]));
                check("u2_any_edge", 64'(any2), 64'h1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        sig0 = 8'hFF; mode0 = 2'b00; flag_clr0 = 8'h00; cnt_clr0 = 1'b0;
        sig1 = 4'h0;  cnt_clr1 = 1'b0;
        sig2 = 4'h0;
        repeat (3) tick();
        check("reset_pulse", 64'(pulse0), 64'h0);
        check("reset_flag", 64'(flag0), 64'h0);
        check("reset_cnt", cnt0, 64'h0);
        check("reset_any", 64'(any0), 64'h0);

        // Inputs high at release: one rising edge on every channel
        rst_n = 1'b1;
        push0(cyc + 3, 8'hFF);
        repeat (6) tick();
        check("release_flag", 64'(flag0), 64'hFF);
        check("release_cnt", cnt0, 64'h0101_0101_0101_0101);

        sig0 = 8'h00;
        repeat (5) tick();
        cnt_clr0 = 1'b1; tick(); cnt_clr0 = 1'b0;
        check("cnt_clr", cnt0, 64'h0);
        flag_clr0 = 8'hFF; tick(); flag_clr0 = 8'h00;
        check("flag_clr_all", 64'(flag0), 64'h0);

        // Single rising edge on channel 3, two-stage latency
        sig0 = 8'h08;
        push0(cyc + 3, 8'h08);
        repeat (2) tick();
        check("ch3_not_early", 64'(pulse0), 64'h0);
        tick();
        check("ch3_pulse", 64'(pulse0), 64'h08);
        check("ch3_any", 64'(any0), 64'h1);
        tick();
        check("ch3_one_cycle", 64'(pulse0), 64'h0);
        check("ch3_flag", 64'(flag0), 64'h08);
        check("ch3_cnt", cnt0, 64'h0000_0000_0100_0000);
        sig0 = 8'h00;
        repeat (4) tick();

        // Both-edge mode, toggling every cycle
        mode0 = 2'b10;
        for (int i = 0; i < 10; i++) begin
            sig0[0] = ~sig0[0];
            push0(cyc + 3, 8'h01);
            tick();
        end
        repeat (5) tick();
        check("both_cnt", cnt0, 64'h0000_0000_0100_000A);

        // Disabled mode: no pulses, counts frozen
        mode0 = 2'b11;
        for (int i = 0; i < 10; i++) begin
            sig0[0] = ~sig0[0];
            tick();
        end
        repeat (5) tick();
        check("disabled_cnt", cnt0, 64'h0000_0000_0100_000A);
        mode0 = 2'b00;
        tick();

        // Coincident set and clear on channel 2: set wins
        flag_clr0 = 8'hFF; tick(); flag_clr0 = 8'h00;
        sig0 = 8'h04;
        push0(cyc + 3, 8'h04);
        repeat (2) tick();
        flag_clr0 = 8'h04; tick(); flag_clr0 = 8'h00;
        check("flag_set_wins", 64'(flag0), 64'h04);
        flag_clr0 = 8'h04; tick(); flag_clr0 = 8'h00;
        check("flag_clr_alone", 64'(flag0), 64'h0);
        check("ch2_cnt", cnt0, 64'h0000_0000_0101_000A);

        // Mode switched to falling while a fall is in the synchroniser
        sig0 = 8'h00;
        push0(cyc + 3, 8'h04);
        tick();
        mode0 = 2'b01;
        repeat (4) tick();
        check("fall_flag", 64'(flag0), 64'h04);
        mode0 = 2'b00;
        tick();

        // Asynchronous reset while a pulse is high
        sig0 = 8'h20;
        repeat (3) tick();
        check("mid_pulse_before_rst", 64'(pulse0), 64'h20);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_pulse", 64'(pulse0), 64'h0);
        check("mid_rst_flag", 64'(flag0), 64'h0);
        check("mid_rst_cnt", cnt0, 64'h0);
        check("mid_rst_any", 64'(any0), 64'h0);
        sig0 = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // u1: 2-bit counter saturation, then clear with coincident edge
        for (int i = 0; i < 5; i++) begin
            sig1[1] = 1'b1; repeat (3) tick();
            sig1[1] = 1'b0; repeat (3) tick();
        end
        check("u1_saturate", 64'(cnt1), 64'h0C);
        sig1[1] = 1'b1;
        repeat (2) tick();
        cnt_clr1 = 1'b1; tick(); cnt_clr1 = 1'b0;
        check("u1_clr_with_edge", 64'(cnt1), 64'h04);
        check("u1_flag", 64'(flag1), 64'h2);
        sig1 = 4'h0;
        repeat (3) tick();

        // u2: no synchroniser, one-cycle latency
        sig2 = 4'b0101;
        push2(cyc + 1, 8'h05);
        repeat (3) tick();
        sig2 = 4'b0000;
        repeat (2) tick();
        sig2 = 4'b1000;
        push2(cyc + 1, 8'h08);
        repeat (3) tick();
        check("u2_cnt", 64'(cnt2), 64'h0101_0001);

        repeat (4) tick();
        check("q0_drained", 64'(q0.size()), 64'h0);
        check("q2_drained", 64'(q2.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
